// File: rtl/ysyx_22040729_ifu_pkg.sv
// Shared encodings and constants for the instruction fetch unit.
package ysyx_22040729_ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/ysyx_22040729_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch, hands words to decode.
// Optional misaligned-PC trap path enabled by defining YSYX_22040729_IFU_MISALIGN_EN.
module ysyx_22040729_ifu
    import ysyx_22040729_ifu_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH = 64,
    parameter int unsigned              INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = 64'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDR_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]   imem_rsp_data,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [INST_WIDTH-1:0]   inst,
    output logic [ADDR_WIDTH-1:0]   inst_pc,
    output logic                    inst_misaligned
);

`ifdef YSYX_22040729_IFU_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    ifu_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  drop;
    logic                  mis_q;
    logic                  misal;
    logic                  req_fire;

    // A misaligned PC never reaches memory; it is reported to decode instead.
    assign misal    = MISALIGN_EN && (pc[1:0] != 2'b00);
    assign req_fire = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (req_fire)                      state_nxt = S_WAIT;
                else if (misal && !redirect_valid) state_nxt = S_OUT;
            end
            S_WAIT: begin
                if (imem_rsp_valid)
                    state_nxt = (redirect_valid || drop) ? S_REQ : S_OUT;
            end
            S_OUT: begin
                if (redirect_valid || inst_ready) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_REQ) && !rst && !misal;
        imem_req_addr  = pc;
    end

    assign inst_valid      = (state == S_OUT);
    assign inst_misaligned = mis_q && MISALIGN_EN;

    // drop marks an accepted request whose response must be swallowed after a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            drop    <= 1'b0;
            inst    <= INST_WIDTH'(NOP_INST);
            inst_pc <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        drop <= req_fire;
                    end else if (misal) begin
                        inst    <= INST_WIDTH'(NOP_INST);
                        inst_pc <= pc;
                        mis_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        drop <= !imem_rsp_valid;
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            inst    <= imem_rsp_data;
                            inst_pc <= pc;
                        end
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        mis_q <= 1'b0;
                    end else if (inst_ready) begin
                        pc    <= pc + ADDR_WIDTH'(INST_BYTES);
                        mis_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040729_ifu.sv
// Directed bench for ysyx_22040729_ifu with a scoreboard of expected deliveries.
module tb_ysyx_22040729_ifu;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_misaligned;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    ysyx_22040729_ifu dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_misaligned(inst_misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, accept it, respond after lat cycles.
    task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int lat);
        int n = 0;
        while (!imem_req_valid && n < 20) begin tick(); n++; end
        chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("req_drop_after_accept", {63'd0, imem_req_valid}, 64'd0);
        for (int i = 1; i < lat; i++) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_q.push_back('{inst: data, pc: addr, mis: 1'b0});
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    // Hold decode off for `hold` cycles, then pop the scoreboard and consume.
    task automatic consume(input int hold, input logic redir, input logic [63:0] rpc);
        exp_t e;
        chk("inst_valid", {63'd0, inst_valid}, 64'd1);
        if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            e = '0;
        end else e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            imem_rsp_valid = (i == 0);
            imem_rsp_data  = 32'hFFFF_FFFF;
            tick();
            imem_rsp_valid = 1'b0;
            chk("hold_inst", {32'd0, inst}, {32'd0, e.inst});
            chk("hold_pc", inst_pc, e.pc);
            chk("hold_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        chk("inst", {32'd0, inst}, {32'd0, e.inst});
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_mis", {63'd0, inst_misaligned}, {63'd0, e.mis});
        inst_ready     = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("inst_valid_drop", {63'd0, inst_valid}, 64'd0);
        chk("mis_clear", {63'd0, inst_misaligned}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_mis", {63'd0, inst_misaligned}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'h13);
        chk("rst_inst_pc", inst_pc, 64'd0);
        rst = 1'b0;
        tick();

        // Basic fetch, 2-cycle response latency.
        fetch(64'h8000_0000, 32'h0000_0513, 2);
        consume(0, 1'b0, '0);

        // Decode stalls 5 cycles; stray response in S_OUT must be ignored.
        fetch(64'h8000_0004, 32'h0010_0093, 1);
        consume(5, 1'b0, '0);

        // Redirect while waiting: the late response is discarded.
        fetch_req_only(64'h8000_0008);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("drop_no_valid", {63'd0, inst_valid}, 64'd0);
        chk("drop_req_addr", imem_req_addr, 64'h8000_0100);

        // Redirect coincident with the response.
        fetch_req_only(64'h8000_0100);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_0BAD;
        tick();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        chk("coinc_no_valid", {63'd0, inst_valid}, 64'd0);
        chk("coinc_req_addr", imem_req_addr, 64'h8000_0200);
        fetch(64'h8000_0200, 32'h0020_0113, 3);
        consume(0, 1'b0, '0);

        // Handshake and redirect in the same S_OUT cycle.
        fetch(64'h8000_0204, 32'h0030_0193, 1);
        consume(0, 1'b1, 64'h8000_0040);
        chk("redir_out_addr", imem_req_addr, 64'h8000_0040);

        // PC wraps silently at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0213, 1);
        consume(0, 1'b0, '0);
        chk("wrap_addr", imem_req_addr, 64'd0);

`ifdef YSYX_22040729_IFU_MISALIGN_EN
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        chk("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
        exp_q.push_back('{inst: 32'h0000_0013, pc: 64'h8000_0002, mis: 1'b1});
        tick();
        consume(0, 1'b0, '0);
        chk("mis_next_addr", imem_req_addr, 64'h8000_0006);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Accept a request at addr without responding yet.
    task automatic fetch_req_only(input logic [63:0] addr);
        int n = 0;
        while (!imem_req_valid && n < 20) begin tick(); n++; end
        chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

endmodule
